// File: rtl/bpm_display_pkg.sv
// Shared types and constants for the BPM seven-segment display stage:
// FSM states, segment codes and the double-dabble correction step.
package bpm_display_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        UPDATE  = 2'd2
    } state_e;

    localparam int BIN_W      = 16;
    localparam int BCD_DIGITS = 5;
    localparam int BCD_W      = BCD_DIGITS * 4;

    // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h40;

    localparam logic [6:0] DIGIT_SEG [10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    // Add 3 to every BCD nibble that is 5 or more, ahead of the next left shift
    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] res;
        res = bcd;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end else begin
                res[4*i +: 4] = bcd[4*i +: 4];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bpm_hex_display_if.sv
// Bundle of the value input, freeze control and display outputs of the
// BPM hex display stage.
interface bpm_hex_display_if;

    logic [15:0] value_in;
    logic        freeze;
    logic [6:0]  HEX0;
    logic [6:0]  HEX1;
    logic [6:0]  HEX2;
    logic [6:0]  HEX3;
    logic        busy;
    logic        overflow;

    modport master (
        output value_in, freeze,
        input  HEX0, HEX1, HEX2, HEX3, busy, overflow
    );

    modport slave (
        input  value_in, freeze,
        output HEX0, HEX1, HEX2, HEX3, busy, overflow
    );

endinterface

// File: rtl/seg7_digit_encode.sv
// Combinational seven-segment encoder for one digit; dash wins over blank,
// and ACTIVE_LOW selects the board polarity.
module seg7_digit_encode
    import bpm_display_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] nibble_i,
    input  logic       blank_i,
    input  logic       dash_i,
    output logic [6:0] seg_o
);

    logic [6:0] seg_ah_s;

    // Pick the active-high pattern for this digit
    always_comb begin
        seg_ah_s = SEG_BLANK;
        if (dash_i) begin
            seg_ah_s = SEG_DASH;
        end else if (blank_i) begin
            seg_ah_s = SEG_BLANK;
        end else if (nibble_i < 4'd10) begin
            seg_ah_s = DIGIT_SEG[nibble_i];
        end else begin
            seg_ah_s = SEG_BLANK;
        end
    end

    assign seg_o = ACTIVE_LOW ? ~seg_ah_s : seg_ah_s;

endmodule

// File: rtl/bpm_hex_display.sv
// Throttled BPM display: samples value_in at REFRESH_HZ, converts it to BCD
// with a one-shift-per-clock double-dabble, and registers blanked/dashed digits.
module bpm_hex_display
    import bpm_display_pkg::*;
#(
    parameter int CLK_HZ              = 50_000_000,
    parameter int REFRESH_HZ          = 100,
    parameter bit ACTIVE_LOW          = 1'b1,
    parameter bit BLANK_LEADING_ZEROS = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    bpm_hex_display_if.slave disp
);

    localparam int DIV   = CLK_HZ / REFRESH_HZ;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [6:0]       BLANK_OUT = ACTIVE_LOW ? 7'h7F : 7'h00;

    // The conversion takes 17 cycles; a shorter refresh period would overrun it
    if (DIV < 32) begin : g_div_check
        $error("bpm_hex_display: CLK_HZ/REFRESH_HZ must be at least 32");
    end

    logic [CNT_W-1:0] cnt_q;
    logic             tick_q;
    state_e           state_q, state_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic [3:0]       iter_q, iter_d;
    logic [6:0]       hex_q [4];
    logic [6:0]       hex_d [4];
    logic             ovf_q, ovf_d;
    logic             busy_q;

    logic [BCD_W-1:0] adj_s;
    logic [3:0]       digit_s [4];
    logic [3:0]       blank_s;
    logic             ovf_s;
    logic [6:0]       seg_s [4];

    // Refresh divider producing a registered one-cycle tick on count DIV-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= (cnt_q == CNT_LAST);
            if (cnt_q == CNT_LAST) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign adj_s = dabble_adjust(bcd_q);
    assign ovf_s = (bcd_q[4*4 +: 4] != 4'd0);

    for (genvar g = 0; g < 4; g++) begin : g_digit
        assign digit_s[g] = bcd_q[4*g +: 4];

        seg7_digit_encode #(
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_enc (
            .nibble_i (digit_s[g]),
            .blank_i  (blank_s[g]),
            .dash_i   (ovf_s),
            .seg_o    (seg_s[g])
        );
    end

    // Leading-zero blanking; the ones digit always shows
    always_comb begin
        blank_s = 4'b0000;
        if (BLANK_LEADING_ZEROS) begin
            blank_s[3] = (digit_s[3] == 4'd0);
            blank_s[2] = (digit_s[3] == 4'd0) && (digit_s[2] == 4'd0);
            blank_s[1] = (digit_s[3] == 4'd0) && (digit_s[2] == 4'd0) && (digit_s[1] == 4'd0);
        end else begin
            blank_s = 4'b0000;
        end
    end

    // FSM next state and conversion datapath
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        iter_d  = iter_q;
        hex_d   = hex_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (tick_q && !disp.freeze) begin
                    bin_d   = disp.value_in;
                    bcd_d   = '0;
                    iter_d  = 4'd0;
                    state_d = CONVERT;
                end else begin
                    state_d = IDLE;
                end
            end
            CONVERT: begin
                {bcd_d, bin_d} = {adj_s, bin_q} << 1;
                iter_d         = iter_q + 4'd1;
                if (iter_q == 4'd15) begin
                    state_d = UPDATE;
                end else begin
                    state_d = CONVERT;
                end
            end
            UPDATE: begin
                hex_d   = seg_s;
                ovf_d   = ovf_s;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, conversion and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            iter_q  <= 4'd0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                hex_q[i] <= BLANK_OUT;
            end
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            iter_q  <= iter_d;
            ovf_q   <= ovf_d;
            busy_q  <= (state_d != IDLE);
            hex_q   <= hex_d;
        end
    end

    assign disp.HEX0     = hex_q[0];
    assign disp.HEX1     = hex_q[1];
    assign disp.HEX2     = hex_q[2];
    assign disp.HEX3     = hex_q[3];
    assign disp.busy     = busy_q;
    assign disp.overflow = ovf_q;

endmodule
